// File: rtl/xgriscv_fetch_queue_pkg.sv
// +--------------------------------------------------------------------+
// | xgriscv_fetch_queue_pkg: core-wide fetch front-end defaults         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package xgriscv_fetch_queue_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam int FQ_DEPTH   = 4;
  localparam int PC_STEP    = 4;

endpackage

`default_nettype wire

// File: rtl/xgriscv_fq_fifo.sv
// +--------------------------------------------------------------------+
// | xgriscv_fq_fifo: DEPTH-entry circular buffer, push/pop/flush        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module xgriscv_fq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      r_mem[r_wr] <= wdata;
  end

  // Empty reads return zero so consumers see clean idle outputs.
  assign rdata = (r_count == '0) ? '0 : r_mem[r_rd];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/xgriscv_fetch_queue.sv
// +--------------------------------------------------------------------+
// | xgriscv_fetch_queue: decoupled fetch unit with instruction queue    |
// | Optional same-cycle bypass: define XGRISCV_FQ_BYPASS_EN. Rev 1.0    |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module xgriscv_fetch_queue
  import xgriscv_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_SIZE,
  parameter int                INSTR_W  = INSTR_SIZE,
  parameter int                DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instrD_valid,
  output logic [INSTR_W-1:0] instrD,
  output logic [ADDR_W-1:0]  pcD,
  input  logic               stallD,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] r_fpc;
  logic [CW-1:0]     r_drop;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_outst;
  logic [CW:0]       w_inflight;
  logic [ADDR_W-1:0] w_tag;
  logic [ADDR_W-1:0] w_redirect_aligned;
  logic [QW-1:0]     w_head;
  logic              w_grant;
  logic              w_resp_keep;
  logic              w_q_empty;
  logic              w_q_push;
  logic              w_q_pop;

  assign w_inflight         = {1'b0, w_count} + {1'b0, w_outst};
  assign imem_req           = !reset && !redirect && (w_inflight < (CW+1)'(DEPTH));
  assign imem_addr          = r_fpc;
  assign w_grant            = imem_req && imem_gnt;
  assign w_redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign w_q_empty          = (w_count == '0);
  assign w_resp_keep        = imem_rvalid && (r_drop == '0) && !redirect && !reset;
  assign w_q_pop            = !w_q_empty && !stallD && !redirect;

`ifdef XGRISCV_FQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_resp_keep && w_q_empty;
  // A bypassed response consumed by decode never occupies a queue slot.
  assign w_q_push = w_resp_keep && !(w_bypass && !stallD);
`else
  assign w_q_push = w_resp_keep;
`endif

  // PC tags of granted requests, retired in order as responses return;
  // its occupancy is exactly the outstanding-request count.
  xgriscv_fq_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_grant),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .wdata (r_fpc),
    .rdata (w_tag),
    .count (w_outst)
  );

  xgriscv_fq_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_q_push),
    .pop   (w_q_pop),
    .flush (redirect),
    .wdata ({w_tag, imem_rdata}),
    .rdata (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_fpc <= RESET_PC;
    else if (redirect)
      r_fpc <= w_redirect_aligned;
    else if (w_grant)
      r_fpc <= r_fpc + ADDR_W'(PC_STEP);
  end

  // On redirect every request still outstanding after this cycle is stale.
  always_ff @(posedge clk) begin
    if (reset)
      r_drop <= '0;
    else if (redirect)
      r_drop <= w_outst - CW'(imem_rvalid);
    else if (imem_rvalid && (r_drop != '0))
      r_drop <= r_drop - CW'(1);
  end

  always_comb begin
    instrD_valid   = !w_q_empty;
    {pcD, instrD}  = w_head;
`ifdef XGRISCV_FQ_BYPASS_EN
    if (w_bypass) begin
      instrD_valid = 1'b1;
      pcD          = w_tag;
      instrD       = imem_rdata;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_xgriscv_fetch_queue.sv
// +--------------------------------------------------------------------+
// | tb_xgriscv_fetch_queue: directed bench with in-order latency memory |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_xgriscv_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instrD_valid;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        stallD;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  always #5 clk = ~clk;

  xgriscv_fetch_queue #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instrD_valid (instrD_valid),
    .instrD       (instrD),
    .pcD          (pcD),
    .stallD       (stallD),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: record this cycle's grant, cross the edge, present the response.
  task automatic advance();
    #1;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_rvalid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend_addr[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  // Expects n in-order pops starting at start within budget cycles.
  task automatic expect_stream(input string tag, input logic [31:0] start, input int n, input int budget);
    logic [31:0] e;
    logic [31:0] ne;
    int          got;
    int          left;
    e    = start;
    got  = 0;
    left = budget;
    while (got < n && left > 0) begin
      #1;
      if (instrD_valid && !stallD) begin
        ne = ~e;
        check({tag, "_pc"}, pcD, e);
        check({tag, "_instr"}, instrD, ne);
        e = e + 32'd4;
        got++;
      end
      advance();
      left--;
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    reset       = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stallD      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset values
    advance();
    advance();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instrD_valid, 0);
    check("rst_instr", instrD, 32'h0);
    check("rst_pc", pcD, 32'h0);

    // Streaming with one-cycle memory: one instruction per cycle
    reset = 1'b0;
    #1;
    check("c0_req", imem_req, 1);
    check("c0_addr", imem_addr, 32'h0);
    advance();
    #1;
    check("c1_addr", imem_addr, 32'h4);
`ifdef XGRISCV_FQ_BYPASS_EN
    check("c1_valid", instrD_valid, 1);
    expect_stream("seq", 32'h0, 8, 8);
`else
    check("c1_valid", instrD_valid, 0);
    expect_stream("seq", 32'h0, 8, 9);
`endif

    // Stall for 10 cycles: credit stops requests, nothing lost
    stallD = 1'b1;
    lat    = 1;
    do_reset();
    for (int i = 0; i < 10; i++) advance();
    #1;
    check("stall_req", imem_req, 0);
    check("stall_valid", instrD_valid, 1);
    check("stall_pc", pcD, 32'h0);
    stallD = 1'b0;
    expect_stream("stall_rel", 32'h0, 6, 10);

    // Redirect while stalled with a full queue flushes it
    stallD = 1'b1;
    for (int i = 0; i < 6; i++) advance();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    check("rs_req_in_redirect", imem_req, 0);
    advance();
    redirect = 1'b0;
    #1;
    check("rs_valid_after", instrD_valid, 0);
    check("rs_addr", imem_addr, 32'h300);
    stallD = 1'b0;
    expect_stream("rs_stream", 32'h300, 3, 20);

    // Redirect to unaligned 0x103 with two responses outstanding
    lat = 3;
    do_reset();
    advance();
    advance();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("r2_req_in_redirect", imem_req, 0);
    advance();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    #1;
    check("r2_addr", imem_addr, 32'h100);
    check("r2_req", imem_req, 1);
    expect_stream("r2_stream", 32'h100, 2, 20);

    // Response arriving in the redirect cycle is discarded
    lat = 1;
    do_reset();
    advance();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("rr_rvalid_present", imem_rvalid, 1);
    check("rr_req_in_redirect", imem_req, 0);
    advance();
    redirect = 1'b0;
    #1;
    check("rr_valid_after", instrD_valid, 0);
    check("rr_addr", imem_addr, 32'h200);
    expect_stream("rr_stream", 32'h200, 2, 20);

    // Fetch address wraps past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    advance();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req", imem_req, 1);
    advance();
    #1;
    check("wrap_addr1", imem_addr, 32'h0);
    expect_stream("wrap_stream", 32'hFFFF_FFFC, 3, 20);

    // Reset mid-operation with queued data, outstanding requests and pending drops
    lat    = 3;
    stallD = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) advance();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    advance();
    redirect = 1'b0;
    reset    = 1'b1;
    advance();
    #1;
    check("mr_valid", instrD_valid, 0);
    check("mr_addr", imem_addr, 32'h0);
    check("mr_req", imem_req, 0);
    reset  = 1'b0;
    stallD = 1'b0;
    lat    = 1;
    expect_stream("mr_stream", 32'h0, 3, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
